// File: rtl/car_park_pkg.sv
// Shared types and constants for the car-park sensor interface: command
// encoding, stimulus generator states and the two-bit {a,b} sensor phases.
package car_park_pkg;

   localparam int COUNT_W = 4;

   typedef enum logic [1:0] {
      CMD_ENTER       = 2'b00,
      CMD_EXIT        = 2'b01,
      CMD_ENTER_ABORT = 2'b10,
      CMD_EXIT_ABORT  = 2'b11
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_P1,
      ST_P2,
      ST_P3,
      ST_P4,
      ST_RESP
   } gen_state_t;

   // Sensor phases as {a,b}
   localparam logic [1:0] SENS_IDLE = 2'b00;
   localparam logic [1:0] SENS_A    = 2'b10;
   localparam logic [1:0] SENS_AB   = 2'b11;
   localparam logic [1:0] SENS_B    = 2'b01;

   function automatic logic is_abort(input cmd_t c);
      return (c == CMD_ENTER_ABORT) || (c == CMD_EXIT_ABORT);
   endfunction

   // Entering cars break the outer sensor first, exiting cars the inner one.
   function automatic logic [1:0] first_phase(input cmd_t c);
      return ((c == CMD_ENTER) || (c == CMD_ENTER_ABORT)) ? SENS_A : SENS_B;
   endfunction

endpackage

// File: rtl/car_park_stim_gen_timer.sv
// Loadable down-counter: after a load of N, expire is high in the N-th cycle
// (the last cycle of the interval), then the counter rests at zero.
module stim_phase_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/car_park_stim_gen.sv
// Car-park stimulus generator: turns car commands into the a/b sensor waveform
// and produces the matching expected inc/dec pulses and occupancy count.
module car_park_stim_gen
   import car_park_pkg::*;
#(
   parameter int HOLD      = 2,
   parameter int RESP_LAT  = 1,
   parameter int MAX_COUNT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   input  logic [1:0]         cmd_type,
   output logic               cmd_ready,
   output logic               a,
   output logic               b,
   output logic               inc_exp,
   output logic               dec_exp,
   output logic [COUNT_W-1:0] count_exp,
   output logic               done
);

   localparam int MAX_T = (HOLD > RESP_LAT) ? HOLD : RESP_LAT;
   localparam int TMR_W = $clog2(MAX_T + 1);

   gen_state_t         state_q, state_d;
   cmd_t               cmd_q, cmd_d;
   logic [1:0]         ab_q, ab_d;
   logic               inc_q, inc_d;
   logic               dec_q, dec_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;
   logic               upd_done_q, upd_done_d;
   logic [COUNT_W-1:0] count_q, count_d;

   logic phase_load, phase_exp;
   logic resp_load, resp_exp;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (v >= COUNT_W'(MAX_COUNT)) ? v : v + COUNT_W'(1);
   endfunction

   function automatic logic [COUNT_W-1:0] sat_dec(input logic [COUNT_W-1:0] v);
      return (v == '0) ? v : v - COUNT_W'(1);
   endfunction

   stim_phase_timer #(.CNT_W(TMR_W)) u_phase_tmr (
      .clk      (clk),
      .reset    (reset),
      .load     (phase_load),
      .load_val (TMR_W'(HOLD)),
      .expire   (phase_exp)
   );

   // Started at the first P4 cycle; expiry lands one cycle before the pulse.
   stim_phase_timer #(.CNT_W(TMR_W)) u_resp_tmr (
      .clk      (clk),
      .reset    (reset),
      .load     (resp_load),
      .load_val (TMR_W'(RESP_LAT)),
      .expire   (resp_exp)
   );

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      ab_d       = ab_q;
      done_d     = 1'b0;
      phase_load = 1'b0;
      resp_load  = 1'b0;
      inc_d      = resp_exp && (cmd_q == CMD_ENTER);
      dec_d      = resp_exp && (cmd_q == CMD_EXIT);
      upd_done_d = upd_done_q | inc_q | dec_q;
      count_d    = count_q;
      if (inc_q)
         count_d = sat_inc(count_q);
      else if (dec_q)
         count_d = sat_dec(count_q);

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && ready_q) begin
               cmd_d      = cmd_t'(cmd_type);
               ab_d       = first_phase(cmd_t'(cmd_type));
               state_d    = ST_P1;
               phase_load = 1'b1;
               upd_done_d = 1'b0;
            end
         end
         ST_P1: begin
            if (phase_exp) begin
               phase_load = 1'b1;
               if (is_abort(cmd_q)) begin
                  state_d = ST_P4;
                  ab_d    = SENS_IDLE;
               end else begin
                  state_d = ST_P2;
                  ab_d    = SENS_AB;
               end
            end
         end
         ST_P2: begin
            if (phase_exp) begin
               phase_load = 1'b1;
               state_d    = ST_P3;
               ab_d       = (cmd_q == CMD_ENTER) ? SENS_B : SENS_A;
            end
         end
         ST_P3: begin
            if (phase_exp) begin
               phase_load = 1'b1;
               resp_load  = 1'b1;
               state_d    = ST_P4;
               ab_d       = SENS_IDLE;
            end
         end
         // Leave only once the expected count update is already visible.
         ST_P4: begin
            if (phase_exp) begin
               if (is_abort(cmd_q) || upd_done_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (upd_done_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cmd_q      <= CMD_ENTER;
         ab_q       <= SENS_IDLE;
         inc_q      <= 1'b0;
         dec_q      <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b1;
         upd_done_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         ab_q       <= ab_d;
         inc_q      <= inc_d;
         dec_q      <= dec_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
         upd_done_q <= upd_done_d;
         count_q    <= count_d;
      end
   end

   assign cmd_ready = ready_q;
   assign a         = ab_q[1];
   assign b         = ab_q[0];
   assign inc_exp   = inc_q;
   assign dec_exp   = dec_q;
   assign count_exp = count_q;
   assign done      = done_q;

endmodule
